// File: rtl/decoder_pkg.sv
// Shared fixed-point definitions for the decoder datapath.
// Sign-magnitude words: bit 31 sign, bits 30:27 integer, bits 26:0 fraction.
package decoder_pkg;

    localparam int BITSIZE   = 32;
    localparam int FRAC_BITS = 27;

    localparam logic [BITSIZE-1:0] FX_ONE  = 32'h0800_0000;
    localparam logic [BITSIZE-1:0] FX_HALF = 32'h0400_0000;
    localparam logic [BITSIZE-1:0] FX_TWO  = 32'h1000_0000;

    typedef struct packed {
        logic               sign;
        logic [BITSIZE-2:0] mag;
    } sm_word_t;

    // Debug view of the activation sequencer: FSM state and the clamp flag of
    // the element currently being activated.
    typedef struct packed {
        logic [1:0] state;
        logic       elem_sat;
    } act_dbg_t;

endpackage

// File: rtl/decoder_activation_seq_if.sv
// Input and output vector handshakes of the activation stage.
interface decoder_activation_seq_if #(
    parameter int M_output = 9,
    parameter int BITSIZE  = 32
);
    // Both channels use valid/ready: a transfer happens on a rising clock edge
    // where valid and ready are both 1; the source holds valid and data stable
    // until that edge, and ready may depend on the sink's state only.
    logic                        in_valid;
    logic                        in_ready;
    logic [M_output*BITSIZE-1:0] in_data;
    logic                        out_valid;
    logic                        out_ready;
    logic [M_output*BITSIZE-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/hard_sigmoid_sm.sv
// Combinational hard-sigmoid on one sign-magnitude word: 0.5 + x/4 clamped to [0, 1].
module hard_sigmoid_sm
    import decoder_pkg::*;
(
    input  sm_word_t x,
    output sm_word_t y,
    output logic     sat
);

    logic [BITSIZE-2:0] q;

    always_comb begin
        q   = x.mag >> 2;
        sat = (x.mag >= FX_TWO[BITSIZE-2:0]);
        y   = '0;
        if (sat) begin
            y = x.sign ? sm_word_t'('0) : sm_word_t'(FX_ONE);
        end else if (x.sign) begin
            // q < 0.5 here, so the difference never goes negative.
            y = sm_word_t'(FX_HALF - {1'b0, q});
        end else begin
            y = sm_word_t'(FX_HALF + {1'b0, q});
        end
    end

endmodule

// File: rtl/decoder_activation_seq.sv
// Captures a decoder result vector, activates one element per cycle, then offers it downstream.
// Optional DEC_ACT_SATCOUNT_EN adds sat_count: number of clamped elements in the current vector.
module decoder_activation_seq
    import decoder_pkg::*;
#(
    parameter int M_output = 9,
    parameter int BITSIZE  = decoder_pkg::BITSIZE
) (
    input  logic                     clk,
    input  logic                     rst_n,
    decoder_activation_seq_if.slave  bus,
    output act_dbg_t                 dbg
`ifdef DEC_ACT_SATCOUNT_EN
    ,
    output logic [$clog2(M_output+1)-1:0] sat_count
`endif
);

    localparam int IDX_W = $clog2(M_output);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(M_output - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]                  state;
    logic [IDX_W-1:0]            idx;
    logic [M_output*BITSIZE-1:0] in_buf;
    logic [M_output*BITSIZE-1:0] out_reg;
    sm_word_t                    cur;
    sm_word_t                    act_y;
    logic                        act_sat;

`ifdef DEC_ACT_SATCOUNT_EN
    logic [$clog2(M_output+1)-1:0] sat_cnt;
    assign sat_count = sat_cnt;
`endif

    assign cur = sm_word_t'(in_buf[int'(idx)*BITSIZE +: BITSIZE]);

    hard_sigmoid_sm u_act (
        .x   (cur),
        .y   (act_y),
        .sat (act_sat)
    );

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.out_data  = out_reg;

    assign dbg.state    = state;
    assign dbg.elem_sat = act_sat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            idx     <= '0;
            in_buf  <= '0;
            out_reg <= '0;
`ifdef DEC_ACT_SATCOUNT_EN
            sat_cnt <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        in_buf  <= bus.in_data;
                        idx     <= '0;
                        state   <= RUN;
`ifdef DEC_ACT_SATCOUNT_EN
                        sat_cnt <= '0;
`endif
                    end
                end
                RUN: begin
                    // out_reg keeps the previous vector in slots not yet rewritten.
                    out_reg[int'(idx)*BITSIZE +: BITSIZE] <= act_y;
`ifdef DEC_ACT_SATCOUNT_EN
                    if (act_sat) sat_cnt <= sat_cnt + 1'b1;
`endif
                    if (idx == LAST_IDX) begin
                        state <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/decoder_activation_seq.md
# decoder_activation_seq

Sequential output-activation stage directly downstream of `decoder_fixed_point`. It captures the decoder's flattened M_output-word result vector through a valid/ready handshake. It then applies a hard-sigmoid to one element per cycle and presents the activated vector to the next consumer through a second valid/ready handshake. Number format matches the decoder: 32-bit sign-magnitude, bit 31 sign, bits 30:27 integer, bits 26:0 fraction.

## Interface
Parameters:
- `M_output`, 9, number of vector elements
- `BITSIZE`, 32, word width (format fixed at 1 sign / 4 int / 27 frac)

Ports:
- `clk`  input  1  rising-edge clock; one clock domain
- `rst_n`  input  1  reset, asynchronous and active-low
- `in_valid`  input  1  decoder vector valid
- `in_ready`  output  1  stage can accept a vector
- `in_data`  input  M_output*BITSIZE  decoder output, element i at `[(i+1)*BITSIZE-1 -: BITSIZE]`
- `out_valid`  output  1  activated vector valid
- `out_ready`  input  1  consumer accepts vector
- `out_data`  output  M_output*BITSIZE  activated vector, same packing

## Operation
- FSM states: IDLE, RUN, DONE. Element counter `idx`, width $clog2(M_output).
- IDLE: `in_ready`=1. On `in_valid && in_ready`, latch `in_data` into the input buffer, clear `idx` to 0, and go to RUN.
- RUN: each cycle, activate element `idx` and write it into the output register slot `idx`. If `idx==M_output-1`, go to DONE. Otherwise increment `idx`.
- DONE: `out_valid`=1 and `out_data` is stable. On `out_ready`, go to IDLE. While `out_ready`=0, hold indefinitely.
- `in_ready`=0 in RUN and DONE. Vectors do not overlap.
- Hard sigmoid, with magnitude m = x[30:0]:
  - m ≥ 2.0 (0x10000000) and sign 0 → 1.0 (0x08000000).
  - m ≥ 2.0 and sign 1 → 0.0 (0x00000000).
  - Otherwise q = m>>2 (truncate). Sign 0 → 0.5+q. Sign 1 → 0.5−q. 0.5 = 0x04000000.
  - Negative zero (0x80000000) → 0x04000000.
  - Result sign bit is always 0. No rounding; the truncation error is ≤ 2^-27.
- `out_data` keeps its last value after the DONE→IDLE transition until it is overwritten element by element in the next RUN.

## Timing
- Reset values: state IDLE, `in_ready`=1, `out_valid`=0, `out_data`=0, `idx`=0, input buffer=0.
- Latency: for an accept at edge t, `out_valid` rises after edge t+M_output (M_output RUN cycles). Minimum accept-to-accept period is M_output+2 cycles when `out_ready` is held at 1.
- Asserting `rst_n` mid-RUN or mid-DONE returns the block to IDLE immediately and clears all outputs. The partial vector is discarded.
- `in_valid` while `in_ready`=0 is ignored. The upstream must hold `in_valid` and `in_data` until accepted.
- `out_ready` outside DONE has no effect.

## Configuration
- `DEC_ACT_SATCOUNT_EN`
  - Defined: adds an output port `sat_count` of width $clog2(M_output+1). It counts the elements in the current vector that hit either clamp (|x| ≥ 2.0). It clears on accept, is valid while `out_valid`=1, and its reset value is 0.
  - Undefined: the port and counter are absent, and all other behaviour is identical.

## Structure
- Shared package `decoder_pkg`:
  - `BITSIZE`, `FRAC_BITS`=27.
  - Constants `FX_ONE`=0x08000000, `FX_HALF`=0x04000000, `FX_TWO`=0x10000000.
  - Sign-magnitude word typedef.
  - This package is also used by `decoder_fixed_point`.
- One sub-module, `hard_sigmoid_sm`: combinational single-word activation with a `sat` flag output. The top level holds the FSM, counter, buffers and handshakes.

## Test plan
- Reset, then idle: `in_ready`=1, `out_valid`=0, `out_data`=0. `out_valid` stays 0 with `in_valid`=0 for 20 cycles.
- Vector [0x08000000, 0x88000000, 0x10000000, 0x90000000, 0x80000000, 0x7FFFFFFF, 0x00000000, 0x02000000, 0x82000000] → [0x06000000, 0x02000000, 0x08000000, 0x00000000, 0x04000000, 0x08000000, 0x04000000, 0x04800000, 0x03800000]. `out_valid` rises exactly 9 cycles after accept. With `DEC_ACT_SATCOUNT_EN`, `sat_count`=3.
- Backpressure: hold `out_ready`=0 for 15 cycles in DONE. `out_valid` and `out_data` stay stable, `in_ready`=0, and `in_valid` pulses are ignored. When `out_ready`=1, one cycle later the block is IDLE with `in_ready`=1.
- Back-to-back: two vectors with `in_valid`/`out_ready` tied high. Both are produced correctly and the accept period is 11 cycles.
- Reset mid-RUN: drop `rst_n` at `idx`=4. `out_data`=0 and `in_ready`=1 immediately. The next vector is processed correctly with no leftover data.
